// File: rtl/ud_counter_pkg.sv
// rtl/ud_counter_pkg.sv - shared limit-mode type for the up/down counter
package ud_counter_pkg;

   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } ud_mode_e;

endpackage

// File: rtl/ud_next_val.sv
// rtl/ud_next_val.sv - combinational next count and wrap flags for one step
module ud_next_val
   import ud_counter_pkg::*;
#(
   parameter int                unsigned WIDTH = 8,
   parameter logic [WIDTH-1:0]  MAX_V = '1,
   parameter ud_mode_e          MODE  = MODE_WRAP
) (
   input  logic [WIDTH-1:0] count,
   input  logic             ud,
   output logic [WIDTH-1:0] nxt,
   output logic             carry,
   output logic             borrow
);

   always_comb begin
      nxt    = count;
      carry  = 1'b0;
      borrow = 1'b0;
      if (ud) begin
         if (count == MAX_V) begin
            if (MODE == MODE_WRAP) begin
               nxt   = '0;
               carry = 1'b1;
            end
         end else begin
            nxt = count + WIDTH'(1);
         end
      end else begin
         if (count == '0) begin
            if (MODE == MODE_WRAP) begin
               nxt    = MAX_V;
               borrow = 1'b1;
            end
         end else begin
            nxt = count - WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/ud_counter_mod.sv
// rtl/ud_counter_mod.sv - up/down counter with load, clear and wrap/saturate limit
module ud_counter_mod
   import ud_counter_pkg::*;
#(
   parameter int unsigned      WIDTH     = 8,
   parameter longint unsigned  MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
   parameter ud_mode_e         MODE      = MODE_WRAP
) (
   input  logic             C,
   input  logic             R,
   input  logic             EN,
   input  logic             UD,
   input  logic             LD,
   input  logic [WIDTH-1:0] D,
   input  logic             CLR,
   output logic [WIDTH-1:0] COUNT,
   output logic             CARRY,
   output logic             BORROW,
   output logic             AT_MAX,
   output logic             AT_ZERO
);

   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("ud_counter_mod: WIDTH must be 2..32");
   end
   if (MAX_COUNT < 64'd1 || MAX_COUNT > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
      $error("ud_counter_mod: MAX_COUNT must be 1..2**WIDTH-1");
   end

   localparam logic [WIDTH-1:0] MAX_V = MAX_COUNT[WIDTH-1:0];

   logic [WIDTH-1:0] step_val;
   logic             step_carry;
   logic             step_borrow;
   logic [WIDTH-1:0] load_val;

   ud_next_val #(
      .WIDTH (WIDTH),
      .MAX_V (MAX_V),
      .MODE  (MODE)
   ) u_next (
      .count  (COUNT),
      .ud     (UD),
      .nxt    (step_val),
      .carry  (step_carry),
      .borrow (step_borrow)
   );

   // Loads above the terminal value are clamped so the range is never left.
   assign load_val = (D > MAX_V) ? MAX_V : D;

   always_ff @(posedge C or negedge R) begin
      if (!R) begin
         COUNT  <= '0;
         CARRY  <= 1'b0;
         BORROW <= 1'b0;
      end else if (CLR) begin
         COUNT  <= '0;
         CARRY  <= 1'b0;
         BORROW <= 1'b0;
      end else if (LD) begin
         COUNT  <= load_val;
         CARRY  <= 1'b0;
         BORROW <= 1'b0;
      end else if (EN) begin
         COUNT  <= step_val;
         CARRY  <= step_carry;
         BORROW <= step_borrow;
      end else begin
         CARRY  <= 1'b0;
         BORROW <= 1'b0;
      end
   end

   assign AT_MAX  = (COUNT == MAX_V);
   assign AT_ZERO = (COUNT == '0);

endmodule

// File: tb/tb_ud_counter_mod.sv
// tb/tb_ud_counter_mod.sv - directed self-checking bench for ud_counter_mod
module tb_ud_counter_mod;
   import ud_counter_pkg::*;

   logic       C = 1'b0;
   logic       R, EN, UD, LD, CLR;
   logic [3:0] D4;
   logic [7:0] D8;

   logic [3:0] w_count, s_count;
   logic [7:0] b_count;
   logic       w_carry, w_borrow, w_at_max, w_at_zero;
   logic       s_carry, s_borrow, s_at_max, s_at_zero;
   logic       b_carry, b_borrow, b_at_max, b_at_zero;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 C = ~C;

   ud_counter_mod #(.WIDTH(4), .MAX_COUNT(9), .MODE(MODE_WRAP)) u_w (
      .C(C), .R(R), .EN(EN), .UD(UD), .LD(LD), .D(D4), .CLR(CLR),
      .COUNT(w_count), .CARRY(w_carry), .BORROW(w_borrow),
      .AT_MAX(w_at_max), .AT_ZERO(w_at_zero)
   );

   ud_counter_mod #(.WIDTH(4), .MAX_COUNT(9), .MODE(MODE_SAT)) u_s (
      .C(C), .R(R), .EN(EN), .UD(UD), .LD(LD), .D(D4), .CLR(CLR),
      .COUNT(s_count), .CARRY(s_carry), .BORROW(s_borrow),
      .AT_MAX(s_at_max), .AT_ZERO(s_at_zero)
   );

   ud_counter_mod u_b (
      .C(C), .R(R), .EN(EN), .UD(UD), .LD(LD), .D(D8), .CLR(CLR),
      .COUNT(b_count), .CARRY(b_carry), .BORROW(b_borrow),
      .AT_MAX(b_at_max), .AT_ZERO(b_at_zero)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge C);
      #1;
   endtask

   task automatic load(input logic [3:0] v4, input logic [7:0] v8);
      LD = 1'b1; EN = 1'b0; CLR = 1'b0; D4 = v4; D8 = v8;
      tick();
      LD = 1'b0;
   endtask

   logic [3:0] up_seq [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
   logic [3:0] sat_up [5]  = '{4'd8, 4'd9, 4'd9, 4'd9, 4'd9};

   initial begin
      R = 1'b0; EN = 1'b0; UD = 1'b0; LD = 1'b0; CLR = 1'b0; D4 = '0; D8 = '0;
      #3;
      chk("rst_count",   32'(w_count),   32'd0);
      chk("rst_carry",   32'(w_carry),   32'd0);
      chk("rst_borrow",  32'(w_borrow),  32'd0);
      chk("rst_at_zero", 32'(w_at_zero), 32'd1);
      chk("rst_at_max",  32'(w_at_max),  32'd0);

      EN = 1'b1; UD = 1'b1; LD = 1'b1; D4 = 4'd5;
      tick();
      chk("rst_ignores_inputs", 32'(w_count), 32'd0);
      LD = 1'b0;
      R = 1'b1;

      // Up count through the wrap: CARRY only on the 9 -> 0 edge.
      for (int i = 0; i < 12; i++) begin
         tick();
         chk($sformatf("up_count[%0d]", i), 32'(w_count), 32'(up_seq[i]));
         chk($sformatf("up_carry[%0d]", i), 32'(w_carry), (i == 9) ? 32'd1 : 32'd0);
         chk($sformatf("up_borrow[%0d]", i), 32'(w_borrow), 32'd0);
      end

      EN = 1'b0; CLR = 1'b1;
      tick();
      chk("clr_count", 32'(w_count), 32'd0);
      CLR = 1'b0; EN = 1'b1; UD = 1'b0;
      tick();
      chk("dn_wrap_count",  32'(w_count),  32'd9);
      chk("dn_wrap_borrow", 32'(w_borrow), 32'd1);
      chk("dn_wrap_carry",  32'(w_carry),  32'd0);
      chk("dn_wrap_at_max", 32'(w_at_max), 32'd1);
      tick();
      chk("dn_next_count",  32'(w_count),  32'd8);
      chk("dn_next_borrow", 32'(w_borrow), 32'd0);

      EN = 1'b0;
      tick();
      chk("hold_count", 32'(w_count), 32'd8);

      // Saturating instance: up from 7, then down from 1.
      load(4'd7, 8'd0);
      EN = 1'b1; UD = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("sat_up[%0d]", i), 32'(s_count), 32'(sat_up[i]));
         chk($sformatf("sat_carry[%0d]", i), 32'(s_carry), 32'd0);
      end
      load(4'd1, 8'd0);
      EN = 1'b1; UD = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk($sformatf("sat_dn[%0d]", i), 32'(s_count), 32'd0);
         chk($sformatf("sat_borrow[%0d]", i), 32'(s_borrow), 32'd0);
      end
      chk("sat_at_zero", 32'(s_at_zero), 32'd1);

      EN = 1'b0; LD = 1'b1; D4 = 4'hC;
      tick();
      chk("ld_clamp", 32'(w_count), 32'd9);
      CLR = 1'b1; D4 = 4'd5;
      tick();
      chk("clr_over_ld", 32'(w_count), 32'd0);
      CLR = 1'b0; EN = 1'b1; UD = 1'b1; D4 = 4'd3;
      tick();
      chk("ld_over_en", 32'(w_count), 32'd3);
      LD = 1'b0; EN = 1'b0;

      // Asynchronous reset between edges.
      load(4'd6, 8'd0);
      chk("pre_async_count", 32'(w_count), 32'd6);
      #2 R = 1'b0;
      #1;
      chk("async_rst_count",  32'(w_count),  32'd0);
      chk("async_rst_carry",  32'(w_carry),  32'd0);
      chk("async_rst_borrow", 32'(w_borrow), 32'd0);
      #1 R = 1'b1;

      load(4'd9, 8'd0);
      EN = 1'b1; UD = 1'b1;
      tick();
      chk("pend_carry", 32'(w_carry), 32'd1);
      EN = 1'b0;
      #2 R = 1'b0;
      #1;
      chk("abort_carry", 32'(w_carry), 32'd0);
      chk("abort_count", 32'(w_count), 32'd0);
      #1 R = 1'b1;

      // Default 8-bit instance toggling direction every edge.
      load(4'd0, 8'h80);
      chk("b_load", 32'(b_count), 32'h80);
      EN = 1'b1;
      for (int i = 0; i < 8; i++) begin
         UD = (i % 2 == 0);
         tick();
         chk($sformatf("b_toggle[%0d]", i), 32'(b_count), (i % 2 == 0) ? 32'h81 : 32'h80);
         chk($sformatf("b_at_max[%0d]", i), 32'(b_at_max), 32'd0);
         chk($sformatf("b_at_zero[%0d]", i), 32'(b_at_zero), 32'd0);
      end
      EN = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
